bench_seq: RTL
==============

Name: bench_seq

Overview:
- Sequencer between the benchmark AXI-lite control slave and the host/card request interface.
- On a start pulse, latches the configuration and issues bench_n_reps request descriptors, each carrying vaddr/len/pid/dest/direction.
- Bounds outstanding requests and counts completions.
- Returns the completion count and elapsed cycles to the control slave for readback.

Parameters:
- N_OUTSTANDING, 8, max issued-but-uncompleted requests (power of 2, ≥1).
- CNT_BITS, 32, width of rep/completion counters.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- bench_ctrl  in  2  one-cycle start pulse; bit0 = read run, bit1 = write run
- bench_vaddr  in  VADDR_BITS  base virtual address
- bench_len  in  LEN_BITS  bytes per request
- bench_pid  in  PID_BITS  process id
- bench_dest  in  DEST_BITS  stream destination
- bench_n_reps  in  32  requests per run
- bench_done  out  32  completions in current/last run
- bench_timer  out  64  cycles from start to last completion
- busy  out  1  run in progress
- req_valid  out  1  descriptor valid
- req_ready  in  1  descriptor accepted
- req_vaddr  out  VADDR_BITS
- req_len  out  LEN_BITS
- req_pid  out  PID_BITS
- req_dest  out  DEST_BITS
- req_wr  out  1  1 = write, 0 = read
- cpl_valid  in  1  one completion per asserted cycle

Behaviour:
- Clock/reset: reset aresetn, synchronous, active-low; clock aclk. Reset mid-run aborts immediately; no requests after reset.
- Reset values: all outputs 0; state IDLE; all counters 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - bench_ctrl != 0 and bench_n_reps != 0 → latch vaddr/len/pid/dest/n_reps; req_wr = bench_ctrl[1] (both bits set = write); clear bench_done and bench_timer; go to ISSUE; busy=1 next cycle.
  - bench_n_reps == 0 → start ignored; bench_done and bench_timer keep their previous values.
- Start latency: first req_valid in the cycle after the start pulse.
- ISSUE:
  - req_valid = 1 while issued < n_reps and outstanding < N_OUTSTANDING.
  - Descriptor is taken when req_valid && req_ready: issued++, outstanding++.
  - Fields and req_valid stay stable while req_valid && !req_ready.
  - After the last descriptor is accepted → DRAIN.
- DRAIN: req_valid = 0. When bench_done reaches n_reps → IDLE, busy=0.
- Completions (ISSUE/DRAIN): cpl_valid → bench_done++, outstanding--.
  - Accept and cpl_valid in the same cycle → outstanding unchanged.
  - cpl_valid in IDLE, or with outstanding == 0, is ignored (no underflow, no count).
- bench_timer: +1 every cycle in ISSUE/DRAIN, including the cycle the final completion arrives; frozen in IDLE until the next valid start.
- Start pulses while busy are ignored; the latched configuration is unaffected by input changes mid-run.
- Counters: issued and bench_done are compared against the latched n_reps at full 32 bits; the outstanding counter is $clog2(N_OUTSTANDING)+1 bits.
- Back-to-back runs: a start arriving in the cycle busy drops is accepted.

Optional Feature:
- Macro BENCH_SEQ_ADDR_INC_EN.
- Defined: req_vaddr = base + k*len for request k (0-based). The running address register adds len on each accept and wraps modulo 2^VADDR_BITS.
- Undefined: every request carries the latched base vaddr.

Decomposition:
- lynxTypes supplies VADDR_BITS, LEN_BITS, PID_BITS, DEST_BITS.
- The run-state enum bench_seq_state_t (IDLE/ISSUE/DRAIN) and a bench_req_t packed struct {vaddr, len, pid, dest, wr} go in the shared package, for reuse by the data-mover side.
- One sub-module is natural: bench_seq_credit, the outstanding-credit counter with inc/dec/full/empty. Everything else is inline.

Test Plan:
- Read run, n_reps=4, len=1024, req_ready=1, 3-cycle completion latency:
  - 4 descriptors with req_wr=0 in consecutive cycles.
  - bench_done=4, busy falls.
  - bench_timer equals cycles from the first ISSUE cycle through the last completion.
- Write run, n_reps=20, N_OUTSTANDING=8, no completions for 50 cycles:
  - Exactly 8 accepted, then req_valid=0.
  - Each cpl_valid releases one more descriptor; final bench_done=20.
- Backpressure: req_ready held low 10 cycles mid-run → req_valid and all fields stable; no issue count change.
- Edge cases: start with n_reps=0 → busy stays 0, no req_valid. Start while busy → ignored. Spurious cpl_valid in IDLE → bench_done unchanged.
- Reset asserted after 3 of 10 requests → all outputs 0 next cycle; the next start runs a clean 10-request run.
- With BENCH_SEQ_ADDR_INC_EN, base 0x1000, len 0x200, n_reps=3 → req_vaddr 0x1000, 0x1200, 0x1400. Without the macro → all three 0x1000.

Source files
------------

// File: rtl/bench_seq_pkg.sv
// Shared types for the benchmark sequencer and the data-mover side.
// Address/length/id widths match the lynxTypes values used by the shell.
package bench_seq_pkg;

    localparam int VADDR_BITS = 48;
    localparam int LEN_BITS   = 28;
    localparam int PID_BITS   = 6;
    localparam int DEST_BITS  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } bench_seq_state_t;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic [PID_BITS-1:0]   pid;
        logic [DEST_BITS-1:0]  dest;
        logic                  wr;
    } bench_req_t;

endpackage

// File: rtl/bench_seq_if.sv
// Request descriptor handshake plus completion strobe between the
// sequencer (master) and the host/card request path (slave).
interface bench_seq_if;

    logic                                 req_valid;
    logic                                 req_ready;
    logic [bench_seq_pkg::VADDR_BITS-1:0] req_vaddr;
    logic [bench_seq_pkg::LEN_BITS-1:0]   req_len;
    logic [bench_seq_pkg::PID_BITS-1:0]   req_pid;
    logic [bench_seq_pkg::DEST_BITS-1:0]  req_dest;
    logic                                 req_wr;
    logic                                 cpl_valid;

    modport master (
        output req_valid, req_vaddr, req_len, req_pid, req_dest, req_wr,
        input  req_ready, cpl_valid
    );

    modport slave (
        input  req_valid, req_vaddr, req_len, req_pid, req_dest, req_wr,
        output req_ready, cpl_valid
    );

endinterface

// File: rtl/bench_seq_credit.sv
// Outstanding-request credit counter: counts issued-but-uncompleted
// requests, saturating at N_OUTSTANDING and never underflowing.
module bench_seq_credit #(
    parameter int N_OUTSTANDING = 8
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam int CW = $clog2(N_OUTSTANDING) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          inc_ok, dec_ok;

    assign full   = (cnt_q == CW'(N_OUTSTANDING));
    assign empty  = (cnt_q == '0);
    assign inc_ok = inc && !full;
    assign dec_ok = dec && !empty;

    // Simultaneous issue and completion leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_ok && !dec_ok) cnt_d = cnt_q + CW'(1);
        else if (!inc_ok && dec_ok) cnt_d = cnt_q - CW'(1);
    end

    // Credit register, synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bench_seq.sv
// Benchmark sequencer: on a start pulse latches the run configuration,
// issues bench_n_reps request descriptors with bounded outstanding count,
// counts completions and measures elapsed cycles for readback.
// Optional macro BENCH_SEQ_ADDR_INC_EN: request k carries base + k*len
// (wrapping); without it every request carries the latched base address.
module bench_seq
    import bench_seq_pkg::*;
#(
    parameter int N_OUTSTANDING = 8,
    parameter int CNT_BITS      = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [1:0]            bench_ctrl,
    input  logic [VADDR_BITS-1:0] bench_vaddr,
    input  logic [LEN_BITS-1:0]   bench_len,
    input  logic [PID_BITS-1:0]   bench_pid,
    input  logic [DEST_BITS-1:0]  bench_dest,
    input  logic [CNT_BITS-1:0]   bench_n_reps,
    output logic [CNT_BITS-1:0]   bench_done,
    output logic [63:0]           bench_timer,
    output logic                  busy,
    bench_seq_if.master           req
);

    bench_seq_state_t    state_q, state_d;
    bench_req_t          desc_q, desc_d;
    logic [CNT_BITS-1:0] n_reps_q, n_reps_d;
    logic [CNT_BITS-1:0] issued_q, issued_d;
    logic [CNT_BITS-1:0] done_q, done_d;
    logic [63:0]         timer_q, timer_d;

    logic start, req_valid, accept, cpl_take, cr_full, cr_empty;

    // A start with zero reps is dropped so the previous results survive.
    assign start     = (bench_ctrl != 2'b00) && (bench_n_reps != '0);
    assign req_valid = (state_q == ISSUE) && (issued_q < n_reps_q) && !cr_full;
    assign accept    = req_valid && req.req_ready;
    assign cpl_take  = (state_q != IDLE) && req.cpl_valid && !cr_empty;

    bench_seq_credit #(
        .N_OUTSTANDING (N_OUTSTANDING)
    ) u_credit (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (accept),
        .dec     (cpl_take),
        .full    (cr_full),
        .empty   (cr_empty)
    );

    // Next-state: run FSM, issue/completion counters, timer, running address.
    always_comb begin
        state_d  = state_q;
        desc_d   = desc_q;
        n_reps_d = n_reps_q;
        issued_d = issued_q;
        done_d   = done_q;
        timer_d  = timer_q;

        if (state_q != IDLE) timer_d = timer_q + 64'd1;
        if (cpl_take)        done_d  = done_q + CNT_BITS'(1);
        if (accept) begin
            issued_d = issued_q + CNT_BITS'(1);
`ifdef BENCH_SEQ_ADDR_INC_EN
            desc_d.vaddr = desc_q.vaddr + VADDR_BITS'(desc_q.len);
`else
            desc_d.vaddr = desc_q.vaddr;
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    desc_d   = '{vaddr: bench_vaddr, len: bench_len, pid: bench_pid,
                                 dest: bench_dest, wr: bench_ctrl[1]};
                    n_reps_d = bench_n_reps;
                    issued_d = '0;
                    done_d   = '0;
                    timer_d  = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE:   if (accept && (issued_d == n_reps_q)) state_d = DRAIN;
            DRAIN:   if (done_d == n_reps_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any run in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            desc_q   <= '0;
            n_reps_q <= '0;
            issued_q <= '0;
            done_q   <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            desc_q   <= desc_d;
            n_reps_q <= n_reps_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            timer_q  <= timer_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign bench_done    = done_q;
    assign bench_timer   = timer_q;
    assign req.req_valid = req_valid;
    assign req.req_vaddr = desc_q.vaddr;
    assign req.req_len   = desc_q.len;
    assign req.req_pid   = desc_q.pid;
    assign req.req_dest  = desc_q.dest;
    assign req.req_wr    = desc_q.wr;

endmodule
